// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg : shared op codes, error bit indices and state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;
  localparam int ERR_ILL  = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_MOD;
  endfunction

  // Overflow is meaningful only for add/sub, divide-by-zero only for div/mod.
  function automatic logic [2:0] mask_err(input logic [3:0] op, input logic [1:0] alu_err);
    logic [2:0] e;
    e = 3'b000;
    e[ERR_OVF]  = alu_err[ERR_OVF]  & ((op == OP_ADD) | (op == OP_SUB));
    e[ERR_DIV0] = alu_err[ERR_DIV0] & ((op == OP_DIV) | (op == OP_MOD));
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if : command and response handshake bundle for alu_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_use_acc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer : registered command front-end for a combinational ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  input  logic        acc_clr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_err,
  output logic [31:0] acc,
  output logic        busy
);

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [2:0]  rsp_err_q, rsp_err_d;
  logic [31:0] acc_q, acc_d;

  logic        w_cmd_fire;
  logic [2:0]  w_cap_err;

  assign w_cmd_fire = bus.cmd_valid && (state_q == ST_IDLE);
  assign w_cap_err  = mask_err(alu_op_q, alu_err);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    acc_d        = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          if (op_is_legal(bus.cmd_op)) begin
            alu_a_d  = bus.cmd_use_acc ? acc_q[15:0] : bus.cmd_a;
            alu_b_d  = bus.cmd_b;
            alu_op_d = bus.cmd_op;
            cnt_d    = c_SETTLE_LOAD;
            state_d  = ST_DRIVE;
          end else begin
            rsp_result_d = 32'd0;
            rsp_err_d    = 3'b100;
            state_d      = ST_RESP;
          end
        end
      end

      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_err_d    = w_cap_err;
          if (w_cap_err == 3'b000) begin
            acc_d = alu_result;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear outranks a same-cycle capture.
    if (acc_clr) begin
      acc_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_a_q      <= 16'd0;
      alu_b_q      <= 16'd0;
      alu_op_q     <= 4'd0;
      rsp_result_q <= 32'd0;
      rsp_err_q    <= 3'b000;
      acc_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      acc_q        <= acc_d;
    end
  end

  // Handshake strobes are forced low while reset is held.
  assign bus.cmd_ready  = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid  = rst_n && (state_q == ST_RESP);
  assign busy           = rst_n && (state_q != ST_IDLE);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
  assign acc            = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer : vector table, hand sequences and random stimulus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_clr = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result = 32'd0;
  logic [1:0]  alu_err = 2'b00;
  logic [31:0] acc;
  logic        busy;
  logic [1:0]  force_err = 2'b00;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_acc = 32'd0;
  logic [15:0] last_a = 16'd0, last_b = 16'd0;
  logic [3:0]  last_op = 4'd0;

  alu_seq_if bus();

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .acc_clr    (acc_clr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .acc        (acc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {err[1:0], result[31:0]}.
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    logic [1:0]  e;
    r = 32'd0;
    e = 2'b00;
    case (op)
      4'd0: begin r = 32'(a) + 32'(b); e[0] = (r > 32'h0000_FFFF); end
      4'd1: begin r = 32'(a) - 32'(b); e[0] = (a < b); end
      4'd2: begin r = 32'(a) * 32'(b); e[0] = (r > 32'h0000_FFFF); end
      4'd3: if (b == 16'd0) e[1] = 1'b1; else r = 32'(a / b);
      4'd4: if (b == 16'd0) e[1] = 1'b1; else r = 32'(a % b);
      default: ;
    endcase
    return {e, r};
  endfunction

  // ALU model with a one-cycle output delay.
  always @(posedge clk) begin
    logic [33:0] t;
    t = alu_fn(alu_op, alu_a, alu_b);
    alu_result <= t[31:0];
    alu_err    <= t[33:32] | force_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ua, input logic [31:0] er, input logic [2:0] ee, input int hold);
    logic        legal;
    logic [15:0] ea;
    int          lat;
    legal = (op <= 4'd4);
    ea    = ua ? exp_acc[15:0] : a;
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = ua;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (legal) begin
      last_a = ea; last_b = b; last_op = op;
    end
    check("alu_a", 32'(alu_a), 32'(last_a));
    check("alu_b", 32'(alu_b), 32'(last_b));
    check("alu_op", 32'(alu_op), 32'(last_op));
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) break;
    end
    check("latency", 32'(lat), legal ? 32'(SETTLE) : 32'd1);
    if (legal && ee == 3'b000) exp_acc = er;
    check("rsp_result", bus.rsp_result, er);
    check("rsp_err", 32'(bus.rsp_err), 32'(ee));
    check("acc", acc, exp_acc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_result", bus.rsp_result, er);
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      if (i == 1 && hold >= 3) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.cmd_a = 16'd1; bus.cmd_b = 16'd1;
        bus.cmd_use_acc = 1'b0;
      end
      if (i == 2) bus.cmd_valid = 1'b0;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
    check("busy_after_rsp", 32'(busy), 32'd0);
    check("alu_a_after_rsp", 32'(alu_a), 32'(last_a));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ua;
    logic [1:0]  frc;
    int          hold;
    logic [31:0] er;
    logic [2:0]  ee;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b, ea;
    logic        ua;
    logic [33:0] t;
    logic [31:0] er;
    logic [2:0]  ee;
    int          seen;

    vt[0]  = '{4'd0, 16'd11,    16'd15,    1'b0, 2'b00, 0, 32'd26,        3'b000};
    vt[1]  = '{4'd1, 16'd32000, 16'd16000, 1'b0, 2'b00, 5, 32'd16000,     3'b000};
    vt[2]  = '{4'd2, 16'd32000, 16'd16000, 1'b0, 2'b00, 0, 32'd512000000, 3'b000};
    vt[3]  = '{4'd2, 16'd0,     16'd2,     1'b1, 2'b00, 0, 32'd65536,     3'b000};
    vt[4]  = '{4'd3, 16'd11,    16'd0,     1'b0, 2'b00, 0, 32'd0,         3'b010};
    vt[5]  = '{4'd2, 16'd3,     16'd4,     1'b0, 2'b01, 0, 32'd12,        3'b000};
    vt[6]  = '{4'd7, 16'd9,     16'd9,     1'b0, 2'b00, 1, 32'd0,         3'b100};
    vt[7]  = '{4'd4, 16'd17,    16'd5,     1'b0, 2'b00, 0, 32'd2,         3'b000};
    vt[8]  = '{4'd0, 16'd65535, 16'd1,     1'b0, 2'b00, 0, 32'd65536,     3'b001};
    vt[9]  = '{4'd1, 16'd5,     16'd9,     1'b0, 2'b00, 0, 32'hFFFF_FFFC, 3'b001};
    vt[10] = '{4'd3, 16'd100,   16'd7,     1'b0, 2'b01, 0, 32'd14,        3'b000};
    vt[11] = '{4'd0, 16'd1,     16'd2,     1'b0, 2'b10, 0, 32'd3,         3'b000};
    vt[12] = '{4'd15, 16'd4,    16'd4,     1'b1, 2'b00, 0, 32'd0,         3'b100};

    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_a = 16'd0; bus.cmd_b = 16'd0;
    bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", acc, 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      force_err = vt[i].frc;
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].ua, vt[i].er, vt[i].ee, vt[i].hold);
      force_err = 2'b00;
    end

    // acc_clr lands on the capture edge
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.cmd_a = 16'd20; bus.cmd_b = 16'd22;
    bus.cmd_use_acc = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    last_a = 16'd20; last_b = 16'd22; last_op = 4'd0;
    repeat (SETTLE - 1) @(posedge clk);
    #1 acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    exp_acc = 32'd0;
    check("clr_cap_valid", 32'(bus.rsp_valid), 32'd1);
    check("clr_cap_result", bus.rsp_result, 32'd42);
    check("clr_cap_acc", acc, 32'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;

    // give acc a nonzero value, then reset in the middle of DRIVE
    send(4'd0, 16'd100, 16'd200, 1'b0, 32'd300, 3'b000, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd2; bus.cmd_a = 16'd7; bus.cmd_b = 16'd6;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    check("drive_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_acc = 32'd0; last_a = 16'd0; last_b = 16'd0; last_op = 4'd0;
    @(negedge clk);
    check("rst_mid_ready_after", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_acc", acc, 32'd0);
    check("rst_mid_alu_a", 32'(alu_a), 32'd0);
    seen = 0;
    repeat (SETTLE + 4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 6));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      ua = 1'($urandom_range(0, 1));
      force_err = 2'($urandom_range(0, 3));
      ea = ua ? exp_acc[15:0] : a;
      t  = alu_fn(op, ea, b);
      if (op > 4'd4) begin
        er = 32'd0;
        ee = 3'b100;
      end else begin
        er = t[31:0];
        ee = 3'b000;
        ee[0] = (t[32] | force_err[0]) & (op == 4'd0 || op == 4'd1);
        ee[1] = (t[33] | force_err[1]) & (op == 4'd3 || op == 4'd4);
      end
      send(op, a, b, ua, er, ee, $urandom_range(0, 2));
      force_err = 2'b00;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
